// File: rtl/int_rs_types_pkg.sv
// Shared types for the integer reservation station: default depth, entry packet, index type.
package int_rs_types_pkg;

    localparam int unsigned RsDepth = 8;

    typedef logic [$clog2(RsDepth)-1:0] rs_idx_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [5:0] rob_idx;
        logic [5:0] psrc1;
        logic [5:0] psrc2;
        logic [5:0] pdst;
        logic       src1_rdy;
        logic       src2_rdy;
    } int_rs_entry_t;

endpackage

// File: rtl/age_matrix_select.sv
// Age matrix over N RS entries plus oldest-requester select.
// age_q[i][j] = 1 means entry i is older than entry j.
module age_matrix_select #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         alloc_en,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         oldest_oh,
    output logic [$clog2(N)-1:0] winner_idx
);

    localparam int unsigned IdxW = $clog2(N);

    logic [N-1:0][N-1:0] age_q, age_d;

    // Newly allocated entries become younger than everything else; ties go to the lower index.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i == j) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_en[i] && alloc_en[j]) begin
                    age_d[i][j] = (i < j);
                end else if (alloc_en[i]) begin
                    age_d[i][j] = 1'b0;
                end else if (alloc_en[j]) begin
                    age_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Entry i wins when it is older than every other requester.
    always_comb begin
        oldest_oh = '0;
        for (int i = 0; i < N; i++) begin
            oldest_oh[i] = request[i]
                && ((~age_q[i] & request & ~(N'(1) << i)) == '0);
        end
    end

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oldest_oh[i]) begin
                winner_idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/int_rs_issue_select.sv
// Integer RS issue stage: oldest-first grant and a one-deep valid/ready issue register.
module int_rs_issue_select
    import int_rs_types_pkg::*;
#(
    parameter int unsigned RS_DEPTH   = RsDepth,
    parameter type         RS_ENTRY_T = int_rs_entry_t
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] alloc_en,
    input  logic [RS_DEPTH-1:0] request,
    input  RS_ENTRY_T           entry_fwd [RS_DEPTH],
    output logic [RS_DEPTH-1:0] grant,
    output logic                issue_valid,
    input  logic                issue_ready,
    output RS_ENTRY_T           issue_entry
);

    localparam int unsigned IdxW = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] oldest_oh;
    logic [IdxW-1:0]     winner_idx;
    logic                can_issue;
    logic                issue_valid_q, issue_valid_d;
    RS_ENTRY_T           issue_entry_q, issue_entry_d;

    age_matrix_select #(
        .N(RS_DEPTH)
    ) u_age (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .request    (request),
        .oldest_oh  (oldest_oh),
        .winner_idx (winner_idx)
    );

    always_comb begin
        can_issue = !flush && rst && (!issue_valid_q || issue_ready);
        grant     = can_issue ? oldest_oh : '0;
    end

    // Grant reads pre-push entry content, so a same-cycle realloc still issues the old uop.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_entry_d = issue_entry_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (|grant) begin
            issue_valid_d = 1'b1;
            issue_entry_d = entry_fwd[winner_idx];
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_valid_q <= 1'b0;
            issue_entry_q <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_entry = issue_entry_q;

endmodule

// File: doc/int_rs_issue_select.md
Name: int_rs_issue_select

Overview:
- Issue stage directly downstream of the integer reservation-station entry array.
- Tracks relative age of all RS entries with an age matrix and grants the oldest requesting entry, at most one per cycle.
- Registers the granted entry, with CDB-forwarded ready bits, into a one-deep issue register.
- The issue register feeds the integer register-read/ALU stage through a valid/ready handshake.

Parameters:
- RS_DEPTH, 8, number of RS entries (>= 2).
- RS_ENTRY_T, int_rs_entry_t, entry packet type.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (asserted when 0).
- flush  in  1  pipeline flush (branch mispredict); kills the issue register and suppresses grant this cycle.
- alloc_en  in  RS_DEPTH  per-entry push strobe; same bits drive the entries' push_en.
- request  in  RS_DEPTH  per-entry ready-to-issue.
- entry_fwd  in  RS_DEPTH x RS_ENTRY_T  per-entry contents with CDB forwarding applied.
- grant  out  RS_DEPTH  one-hot (or zero) issue grant back to the entries.
- issue_valid  out  1  issue register holds a live uop.
- issue_ready  in  1  downstream accepts the issue register this cycle.
- issue_entry  out  RS_ENTRY_T  registered issued uop.

Behaviour:
- Age matrix state: age[i][j] = 1 means entry i is older than entry j. Diagonal is constant 0.
- Reset (rst==0 at a clk edge): all age bits are 0, issue_valid=0, issue_entry=0. grant is combinationally 0 while rst==0.
- Age update on allocation, per allocated entry i:
  - For every j not allocated this cycle: age[j][i]=1 and age[i][j]=0.
  - Among entries allocated in the same cycle: the lower index is older, i.e. age[i][j]=(i<j).
  - Rows and columns of non-allocated entries are otherwise unchanged.
- Select, combinational: candidate i wins if request[i]==1 and, for every j!=i with request[j]==1, age[i][j]==1. Exactly one winner exists whenever any request is set.
- Grant gating:
  - grant = winner one-hot when can_issue, else 0.
  - can_issue = !flush && rst && (!issue_valid || issue_ready).
- Issue register, next-state priority:
  1. flush: issue_valid<=0.
  2. Otherwise, if any grant: issue_valid<=1 and issue_entry<=entry_fwd[winner].
  3. Otherwise, if issue_ready: issue_valid<=0.
  4. Otherwise: hold.
- Latency: request seen at cycle N, grant at cycle N, issue_valid at N+1. Back-to-back issue every cycle while issue_ready=1.
- Stall: issue_valid && !issue_ready gives grant=0, and issue_entry and issue_valid hold stable.
- Simultaneous grant and alloc of the same entry:
  - The entry's push has priority, so the entry becomes the new uop.
  - The age update treats the entry as youngest.
  - The granted (old) content is what is latched into the issue register.
- alloc_en of an entry asserted while that entry requests: grant is still legal this cycle, because age uses pre-update state.
- Flush mid-stall: issue_valid drops next cycle regardless of issue_ready. Age matrix is not cleared by flush, since entries are cleared separately.
- Reset mid-operation: reset state is reached in one cycle, with no partial issue.
- Stale age bits of invalid entries are harmless, because request gates selection.

Decomposition:
- Shared int_rs_types package:
  - RS_DEPTH default constant.
  - int_rs_entry_t.
  - rs_idx_t, width $clog2(RS_DEPTH).
- Sub-module age_matrix_select, parameter N:
  - Holds the age matrix and its alloc update.
  - Outputs the oldest-request one-hot and the winner index.
- The top level adds grant gating and the issue register/handshake.

Test Plan:
- Reset then alloc_en=8'b0000_0001, then 8'b0000_0100, then 8'b0000_0010. Set request=8'b0000_0111 -> grants 0x01, 0x04, 0x02 on successive cycles; issue_entry follows entries 0, 2, 1.
- Same-cycle alloc_en=8'b1000_0001 with no other valid entries, then request both -> grant 0x01 first, 0x80 next.
- issue_ready=0 with issue_valid=1 and request=0xFF -> grant=0 for 3 cycles; issue_entry stable. Raising issue_ready resumes one grant per cycle.
- flush pulse while issue_valid=1 and issue_ready=0 -> issue_valid=0 next cycle and grant=0 during the flush cycle.
- Entry 3 granted while alloc_en[3]=1 in the same cycle, other entries 5 and 6 older, then request 3/5/6 -> issue order 5, 6, 3.
- rst=0 asserted for one cycle mid-stream with issue_valid=1 -> issue_valid=0, grant=0, and all age bits 0 the following cycle.
